// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared 640x480@60 timing constants, sync polarity, the per-pixel control
// word carried down the read pipeline and, when VGA_TESTPAT_EN is defined,
// the colour-bar table and its lookup.
// No ports.

package vga_timing_pkg;

   localparam int H_ACTIVE     = 640;
   localparam int H_FP         = 16;
   localparam int H_SYNC       = 96;
   localparam int H_BP         = 48;
   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

   localparam int V_ACTIVE     = 480;
   localparam int V_FP         = 10;
   localparam int V_SYNC       = 2;
   localparam int V_BP         = 33;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   // Level driven on hsync/vsync during the sync pulse.
   localparam logic SYNC_POL = 1'b0;

   localparam int CNT_W = 10;
   typedef logic [CNT_W-1:0] cnt_t;

   // Per-pixel control travelling alongside the RAM read.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
      logic first;
   } ctl_t;

   localparam ctl_t CTL_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0, 1'b0};

`ifdef VGA_TESTPAT_EN
   localparam int BAR_W = 80;

   // Index 0 is the leftmost bar.
   localparam logic [7:0][15:0] BAR_COLOUR = {
      16'h0000, 16'h001F, 16'hF800, 16'hF81F,
      16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
   };

   // Threshold compare instead of h/80 to keep a divider out of the output stage.
   function automatic logic [15:0] bar_colour(input cnt_t h);
      logic [15:0] c;
      c = BAR_COLOUR[0];
      for (int i = 1; i < 8; i++) begin
         if (h >= cnt_t'(i * BAR_W)) c = BAR_COLOUR[i];
      end
      return c;
   endfunction
`endif

endpackage

// File: rtl/vga_fb_reader_if.sv
// vga_fb_reader_if
// Frame-buffer read port between the scan controller and the RAM.
//   addr_out  read address (reader -> RAM)
//   regread   read enable, high only for active-area addresses
//   data_in   pixel returned by the RAM

interface vga_fb_reader_if #(
   parameter int AW = 17,
   parameter int DW = 16
);
   logic [AW-1:0] addr_out;
   logic          regread;
   logic [DW-1:0] data_in;

   modport master (output addr_out, output regread, input data_in);
   modport slave  (input addr_out, input regread, output data_in);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Free-running 800x525 horizontal/vertical counters with raw (unregistered)
// sync and active-area flags decoded from the current count.
//   clk, rst      pixel clock, synchronous active-high reset
//   h_cnt, v_cnt  current position
//   hsync_raw     active-low horizontal sync for this position
//   vsync_raw     active-low vertical sync for this position
//   active        position lies inside 640x480
//   line_wrap     last cycle of a line
//   frame_wrap    last cycle of a frame

module vga_sync_gen
   import vga_timing_pkg::*;
(
   input  logic clk,
   input  logic rst,
   output cnt_t h_cnt,
   output cnt_t v_cnt,
   output logic hsync_raw,
   output logic vsync_raw,
   output logic active,
   output logic line_wrap,
   output logic frame_wrap
);

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (line_wrap) begin
         h_cnt <= '0;
         v_cnt <= frame_wrap ? '0 : v_cnt + cnt_t'(1);
      end else begin
         h_cnt <= h_cnt + cnt_t'(1);
      end
   end

   always_comb begin
      line_wrap  = (h_cnt == cnt_t'(H_TOTAL - 1));
      frame_wrap = line_wrap && (v_cnt == cnt_t'(V_TOTAL - 1));
      active     = (h_cnt < cnt_t'(H_ACTIVE)) && (v_cnt < cnt_t'(V_ACTIVE));
      hsync_raw  = ((h_cnt >= cnt_t'(H_SYNC_START)) && (h_cnt < cnt_t'(H_SYNC_END)))
                   ? SYNC_POL : ~SYNC_POL;
      vsync_raw  = ((v_cnt >= cnt_t'(V_SYNC_START)) && (v_cnt < cnt_t'(V_SYNC_END)))
                   ? SYNC_POL : ~SYNC_POL;
   end

endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader
// Scan controller for the frame-buffer read side. Produces 640x480@60 timing,
// walks the FB_W x FB_H buffer upscaled by 2^SCALE_SHIFT using only adds,
// and aligns the returned pixel with registered hsync/vsync/de/rgb.
// Counter-to-pin latency is 2+RAM_LAT cycles.
//   clk, rst     pixel clock, synchronous active-high reset
//   fb           frame-buffer read port (addr_out, regread, data_in)
//   test_sel     colour-bar select (only with VGA_TESTPAT_EN)
//   hsync/vsync  active-low syncs
//   de, rgb      active-video flag and pixel (rgb is 0 when de=0)
//   frame_start  one-cycle pulse with pixel (0,0)
// Build option: define VGA_TESTPAT_EN to include the 8-bar test pattern.

module vga_fb_reader
   import vga_timing_pkg::*;
#(
   parameter int FB_W        = 160,
   parameter int FB_H        = 120,
   parameter int SCALE_SHIFT = 2,
   parameter int AW          = 17,
   parameter int DW          = 16,
   parameter int RAM_LAT     = 1
) (
   input  logic              clk,
   input  logic              rst,
   vga_fb_reader_if.master   fb,
   input  logic              test_sel,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [DW-1:0]     rgb,
   output logic              frame_start
);

   localparam int SW        = SCALE_SHIFT;
   // Base of the final buffer row; line_base never moves past it.
   localparam int LAST_BASE = FB_W * (FB_H - 1);

   cnt_t h_cnt, v_cnt;
   logic hsync_raw, vsync_raw, active, line_wrap, frame_wrap;
   logic line_end, first_pix, rd_en;

   vga_sync_gen u_sync (
      .clk        (clk),
      .rst        (rst),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .hsync_raw  (hsync_raw),
      .vsync_raw  (vsync_raw),
      .active     (active),
      .line_wrap  (line_wrap),
      .frame_wrap (frame_wrap)
   );

   assign line_end  = active && (h_cnt == cnt_t'(H_ACTIVE - 1));
   assign first_pix = (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_TESTPAT_EN
   assign rd_en = active && !test_sel;
`else
   assign rd_en = active;
   wire unused_test_sel = test_sel;
`endif

   // pix_addr is the address of the pixel the counters point at now;
   // sub_h/sub_v count repeats of the same buffer column/row.
   logic [AW-1:0] pix_addr, line_base;
   logic [SW-1:0] sub_h, sub_v;

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_addr  <= '0;
         line_base <= '0;
         sub_h     <= '0;
         sub_v     <= '0;
      end else if (frame_wrap) begin
         pix_addr  <= '0;
         line_base <= '0;
         sub_h     <= '0;
         sub_v     <= '0;
      end else if (line_end) begin
         sub_h <= '0;
         sub_v <= sub_v + SW'(1);
         if ((&sub_v) && (line_base != AW'(LAST_BASE))) begin
            line_base <= line_base + AW'(FB_W);
            pix_addr  <= line_base + AW'(FB_W);
         end else begin
            pix_addr  <= line_base;
         end
      end else if (active) begin
         sub_h <= sub_h + SW'(1);
         if (&sub_h) pix_addr <= pix_addr + AW'(1);
      end
   end

   // Stage 1 plus the delay line covering the RAM read latency.
   ctl_t ctl_d [0:RAM_LAT];
`ifdef VGA_TESTPAT_EN
   cnt_t h_d [0:RAM_LAT];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         fb.addr_out <= '0;
         fb.regread  <= 1'b0;
         for (int i = 0; i <= RAM_LAT; i++) ctl_d[i] <= CTL_IDLE;
`ifdef VGA_TESTPAT_EN
         for (int i = 0; i <= RAM_LAT; i++) h_d[i] <= '0;
`endif
      end else begin
         fb.regread <= rd_en;
         if (active) fb.addr_out <= pix_addr;
         ctl_d[0] <= {hsync_raw, vsync_raw, active, first_pix};
         for (int i = 1; i <= RAM_LAT; i++) ctl_d[i] <= ctl_d[i-1];
`ifdef VGA_TESTPAT_EN
         h_d[0] <= h_cnt;
         for (int i = 1; i <= RAM_LAT; i++) h_d[i] <= h_d[i-1];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         de          <= 1'b0;
         rgb         <= '0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= ctl_d[RAM_LAT].hsync;
         vsync       <= ctl_d[RAM_LAT].vsync;
         de          <= ctl_d[RAM_LAT].active;
         frame_start <= ctl_d[RAM_LAT].first;
         rgb         <= ctl_d[RAM_LAT].active ? fb.data_in : '0;
`ifdef VGA_TESTPAT_EN
         if (test_sel) rgb <= ctl_d[RAM_LAT].active ? DW'(bar_colour(h_d[RAM_LAT])) : '0;
`endif
      end
   end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
Read-side scan controller for the dual-port frame buffer. Generates 640x480@60 VGA timing from the pixel clock and issues read addresses and read enable to the buffer's read port. Consumes the returned 16-bit RGB565 pixel and drives registered hsync, vsync, data-enable and rgb toward the DAC/pins. Upscales a FB_W x FB_H buffer by 2^SCALE_SHIFT in both axes using incremental addressing, with no multiplier.

Parameters:
FB_W, 160, frame-buffer width in pixels
FB_H, 120, frame-buffer height in lines
SCALE_SHIFT, 2, log2 of the upscale factor; H_ACTIVE must equal FB_W<<SCALE_SHIFT and V_ACTIVE must equal FB_H<<SCALE_SHIFT
AW, 17, read-address width
DW, 16, pixel width (RGB565)
RAM_LAT, 1, RAM read latency in cycles from registered addr_out to valid data_in

Ports:
clk  in  1  pixel clock (25 MHz)
rst  in  1  synchronous, active-high reset
addr_out  out  AW  frame-buffer read address
regread  out  1  read enable; high only for active-area addresses
data_in  in  DW  pixel data from the buffer read port
test_sel  in  1  selects the test pattern; used only with VGA_TESTPAT_EN
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
de  out  1  active-video flag, aligned with rgb
rgb  out  DW  output pixel; 0 when de=0
frame_start  out  1  one-cycle pulse aligned with the first active pixel of a frame

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous, active-high.
- Reset values: h_cnt=0, v_cnt=0, addr_out=0, regread=0, hsync=1, vsync=1, de=0, rgb=0, frame_start=0, all pipeline registers cleared. Reset asserted mid-frame aborts the frame. The first cycle after release is h=0, v=0.
- Horizontal counter: h_cnt counts 0..799 and wraps.
  - Active 0..639; front porch 640..655; sync 656..751; back porch 752..799.
- Vertical counter: v_cnt increments when h_cnt wraps and counts 0..524.
  - Active 0..479; front porch 480..489; sync 490..491; back porch 492..524.
- Stage 0 (counters): computes active = (h<640)&&(v<480).
- Stage 1 (registered):
  - addr_out = current pixel address; regread = active.
  - raw hsync/vsync/active are captured into the delay line.
- Address generation:
  - addr_out holds its value for 2^SCALE_SHIFT active pixels, then increments by 1.
  - At end of each active line, addr reloads line_base.
  - After every 2^SCALE_SHIFT active lines, line_base += FB_W before the reload.
  - At v wrap, line_base=0 and addr=0.
  - Outside the active area, addr_out holds its last value and regread=0.
  - Maximum address is FB_W*FB_H-1 = 19199; addresses never exceed it.
- Data path: data_in is valid RAM_LAT cycles after stage 1.
- Output stage (registered): rgb = de ? data_in : 0; hsync/vsync/de are delayed to match.
- Total latency from counter to pin: 2+RAM_LAT cycles (3 at default). All outputs are mutually aligned.
- frame_start = 1 on the output cycle carrying pixel (0,0).
- Widths: line_base and addr are AW wide with unsigned arithmetic. There is no wrap inside a frame, by construction.

Optional Feature:
Macro: VGA_TESTPAT_EN
- Defined: when test_sel=1, the output-stage rgb is replaced by 8 vertical colour bars of 80 pixels each, using the delayed h position.
  - Bar order: white 16'hFFFF, yellow 16'hFFE0, cyan 16'h07FF, green 16'h07E0, magenta 16'hF81F, red 16'hF800, blue 16'h001F, black 16'h0000.
  - regread is forced to 0 while test_sel=1.
  - Timing, de and latency are unchanged.
- Undefined: test_sel is ignored, no bar logic is synthesised, and rgb always comes from data_in.

Decomposition:
- Package vga_timing_pkg holds:
  - H_ACTIVE/H_FP/H_SYNC/H_BP/H_TOTAL and the V_* equivalents;
  - the sync polarity constant;
  - the colour-bar constant array.
- Sub-module vga_sync_gen: h/v counters, raw sync and active flags.
- vga_fb_reader holds address generation, the delay line and the output stage.

Test Plan:
- Reset: hold rst=1 for 5 cycles mid-line -> all outputs at reset values. After release, the first de=1 appears exactly 3 cycles later with frame_start=1.
- Line/frame timing: run 2 frames -> hsync low for 96 of every 800 cycles; vsync low for 1600 cycles of every 420000; de high for 640 cycles per line on 480 lines.
- Address sequence: capture addr_out while regread=1 on lines 0..4.
  - Lines 0..3 each give 0,0,0,0,1,1,1,1,...,159.
  - Line 4 starts at 160.
  - The last active pixel of the frame gives 19199.
  - The next frame restarts at 0.
- Data alignment: RAM model with RAM_LAT=1 returning data=addr[15:0] -> rgb equals the expected address for every de=1 cycle, and rgb=0 whenever de=0.
- Reset mid-operation at v=300: assert rst for 1 cycle -> the next frame starts from addr 0, h=0, v=0 with no stray regread.
- VGA_TESTPAT_EN defined, test_sel=1 -> pixels 0..79 are 16'hFFFF, pixels 80..159 are 16'hFFE0, pixels 560..639 are 0; regread stays 0 throughout.
